// File: rtl/rename_regfile_pkg.sv
// Shared defaults and constants for the rename register file.
package rename_regfile_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NREG_DEF     = 32;
    localparam int unsigned TAG_W_DEF    = 5;
    localparam int unsigned COMMIT_W_DEF = 2;

    // Register index width for the default register count
    localparam int unsigned IDX_W_DEF = $clog2(NREG_DEF);

    // x0 is hardwired to zero, never written, never busy
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/rename_regfile_if.sv
// Dispatcher / ReorderBuffer facing bus of the rename register file.
// master: Dispatcher + ReorderBuffer side; slave: the register file.
interface rename_regfile_if #(
    parameter int unsigned XLEN     = rename_regfile_pkg::XLEN_DEF,
    parameter int unsigned NREG     = rename_regfile_pkg::NREG_DEF,
    parameter int unsigned TAG_W    = rename_regfile_pkg::TAG_W_DEF,
    parameter int unsigned COMMIT_W = rename_regfile_pkg::COMMIT_W_DEF
);
    localparam int unsigned IDX_W = $clog2(NREG);

    // Rename request
    logic                      disp_en;
    logic [IDX_W-1:0]          disp_rd;
    logic [TAG_W-1:0]          disp_tag;

    // Operand reads
    logic [IDX_W-1:0]          rs1;
    logic [IDX_W-1:0]          rs2;
    logic [XLEN-1:0]           v1;
    logic [XLEN-1:0]           v2;
    logic [TAG_W-1:0]          q1;
    logic [TAG_W-1:0]          q2;
    logic                      busy1;
    logic                      busy2;

    // Commit ports, port 0 oldest
    logic [COMMIT_W-1:0]       cm_en;
    logic [COMMIT_W*IDX_W-1:0] cm_rd;
    logic [COMMIT_W*TAG_W-1:0] cm_tag;
    logic [COMMIT_W*XLEN-1:0]  cm_val;

    logic                      rollback;

    modport master (
        output disp_en, disp_rd, disp_tag, rs1, rs2,
        output cm_en, cm_rd, cm_tag, cm_val, rollback,
        input  v1, v2, q1, q2, busy1, busy2
    );

    modport slave (
        input  disp_en, disp_rd, disp_tag, rs1, rs2,
        input  cm_en, cm_rd, cm_tag, cm_val, rollback,
        output v1, v2, q1, q2, busy1, busy2
    );

endinterface

// File: rtl/rename_regfile_rdport.sv
// One combinational operand read port: state lookup, x0 masking and,
// with RENAME_REGFILE_BYPASS_EN defined, commit-to-read bypass.
module rename_regfile_rdport
    import rename_regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF,
    parameter int unsigned COMMIT_W = COMMIT_W_DEF,
    localparam int unsigned IDX_W   = $clog2(NREG)
) (
    input  logic [IDX_W-1:0]                 rs,
    input  logic [NREG-1:0][XLEN-1:0]        vs,
    input  logic [NREG-1:0][TAG_W-1:0]       qs,
    input  logic [NREG-1:0]                  busy_vec,
`ifdef RENAME_REGFILE_BYPASS_EN
    input  logic [COMMIT_W-1:0]              cm_en,
    input  logic [COMMIT_W-1:0][IDX_W-1:0]   cm_rd,
    input  logic [COMMIT_W-1:0][TAG_W-1:0]   cm_tag,
    input  logic [COMMIT_W-1:0][XLEN-1:0]    cm_val,
`endif
    output logic [XLEN-1:0]                  v,
    output logic [TAG_W-1:0]                 q,
    output logic                             busy
);

    // Registered lookup, overridden by a matching commit, then x0 mask
    always_comb begin
        v    = vs[rs];
        q    = qs[rs];
        busy = busy_vec[rs];
`ifdef RENAME_REGFILE_BYPASS_EN
        // Later ports overwrite earlier ones, so the highest match wins
        for (int i = 0; i < int'(COMMIT_W); i++) begin
            if (cm_en[i] && cm_rd[i] == rs && busy_vec[rs] && cm_tag[i] == qs[rs]) begin
                v    = cm_val[i];
                q    = '0;
                busy = 1'b0;
            end
        end
`endif
        if (rs == IDX_W'(ZERO_REG)) begin
            v    = '0;
            q    = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags and busy bits.
// Optional commit-to-read bypass: define RENAME_REGFILE_BYPASS_EN.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF,
    parameter int unsigned COMMIT_W = COMMIT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    rename_regfile_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0]         vs_q, vs_n;
    logic [NREG-1:0][TAG_W-1:0]        qs_q, qs_n;
    logic [NREG-1:0]                   busy_q, busy_n;

    logic [COMMIT_W-1:0][IDX_W-1:0]    cm_rd_a;
    logic [COMMIT_W-1:0][TAG_W-1:0]    cm_tag_a;
    logic [COMMIT_W-1:0][XLEN-1:0]     cm_val_a;

    // Split the packed commit buses into per-port fields
    assign cm_rd_a  = bus.cm_rd;
    assign cm_tag_a = bus.cm_tag;
    assign cm_val_a = bus.cm_val;

    // Next state: commits in port order, then rollback or rename on top
    always_comb begin
        vs_n   = vs_q;
        qs_n   = qs_q;
        busy_n = busy_q;
        for (int i = 0; i < int'(COMMIT_W); i++) begin
            if (bus.cm_en[i] && cm_rd_a[i] != IDX_W'(ZERO_REG)) begin
                vs_n[cm_rd_a[i]] = cm_val_a[i];
                // Only the owning (youngest) rename's commit releases the register
                if (busy_q[cm_rd_a[i]] && qs_q[cm_rd_a[i]] == cm_tag_a[i]) begin
                    busy_n[cm_rd_a[i]] = 1'b0;
                end
            end
        end
        if (bus.rollback) begin
            busy_n = '0;
        end else if (bus.disp_en && bus.disp_rd != IDX_W'(ZERO_REG)) begin
            qs_n[bus.disp_rd]   = bus.disp_tag;
            busy_n[bus.disp_rd] = 1'b1;
        end
        vs_n[ZERO_REG]   = '0;
        qs_n[ZERO_REG]   = '0;
        busy_n[ZERO_REG] = 1'b0;
    end

    // State registers; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q   <= '0;
            qs_q   <= '0;
            busy_q <= '0;
        end else if (rdy) begin
            vs_q   <= vs_n;
            qs_q   <= qs_n;
            busy_q <= busy_n;
        end
    end

    rename_regfile_rdport #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W)
    ) u_rdport1 (
        .rs       (bus.rs1),
        .vs       (vs_q),
        .qs       (qs_q),
        .busy_vec (busy_q),
`ifdef RENAME_REGFILE_BYPASS_EN
        .cm_en    (bus.cm_en),
        .cm_rd    (cm_rd_a),
        .cm_tag   (cm_tag_a),
        .cm_val   (cm_val_a),
`endif
        .v        (bus.v1),
        .q        (bus.q1),
        .busy     (bus.busy1)
    );

    rename_regfile_rdport #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W)
    ) u_rdport2 (
        .rs       (bus.rs2),
        .vs       (vs_q),
        .qs       (qs_q),
        .busy_vec (busy_q),
`ifdef RENAME_REGFILE_BYPASS_EN
        .cm_en    (bus.cm_en),
        .cm_rd    (cm_rd_a),
        .cm_tag   (cm_tag_a),
        .cm_val   (cm_val_a),
`endif
        .v        (bus.v2),
        .q        (bus.q2),
        .busy     (bus.busy2)
    );

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expectations are queued as stimulus
// is applied and compared against the read ports afterwards.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    localparam int unsigned IW = IDX_W_DEF;
    localparam int unsigned TW = TAG_W_DEF;
    localparam int unsigned XW = XLEN_DEF;

    logic clk;
    logic rst;
    logic rdy;

    rename_regfile_if rf();

    rename_regfile dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        bit            port;
        logic [IW-1:0] rs;
        logic [XW-1:0] v;
        logic          busy;
        bit            chk_q;
        logic [TW-1:0] q;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    exp_t          e;
    logic [XW-1:0] gv;
    logic [TW-1:0] gq;
    logic          gb;

    task automatic push(input string name, input bit port, input int rs,
                        input logic [XW-1:0] v, input logic busy,
                        input bit chk_q, input int q);
        exp_t x;
        x.name  = name;
        x.port  = port;
        x.rs    = IW'(rs);
        x.v     = v;
        x.busy  = busy;
        x.chk_q = chk_q;
        x.q     = TW'(q);
        sb.push_back(x);
    endtask

    task automatic idle();
        rf.disp_en  = 1'b0;
        rf.disp_rd  = '0;
        rf.disp_tag = '0;
        rf.cm_en    = '0;
        rf.cm_rd    = '0;
        rf.cm_tag   = '0;
        rf.cm_val   = '0;
        rf.rollback = 1'b0;
        rdy         = 1'b1;
    endtask

    task automatic disp(input int rd, input int tag);
        rf.disp_en  = 1'b1;
        rf.disp_rd  = IW'(rd);
        rf.disp_tag = TW'(tag);
    endtask

    task automatic commit(input int p, input int rd, input int tag, input logic [XW-1:0] val);
        rf.cm_en[p]            = 1'b1;
        rf.cm_rd[p*IW +: IW]   = IW'(rd);
        rf.cm_tag[p*TW +: TW]  = TW'(tag);
        rf.cm_val[p*XW +: XW]  = val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int r = 0; r < 32; r++) push("reset_state", 1'b0, r, '0, 1'b0, 1'b1, 0);
        push("reset_state_p2", 1'b1, 0, '0, 1'b0, 1'b1, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    task automatic test_reset_async();
        disp(5, 3);
        step();
        idle();
        push("pre_reset_busy", 1'b0, 5, '0, 1'b1, 1'b1, 3);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
        #2;
        rst = 1'b1;
        push("async_reset", 1'b0, 5, '0, 1'b0, 1'b1, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_rename_commit();
        disp(7, 9);
        step();
        idle();
        push("rename_busy", 1'b0, 7, '0, 1'b1, 1'b1, 9);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
        commit(0, 7, 9, 32'hDEAD_BEEF);
        step();
        idle();
        push("commit_clear", 1'b0, 7, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        push("commit_clear_p2", 1'b1, 7, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    task automatic test_stale_commit();
        disp(7, 9);
        step();
        disp(7, 12);
        step();
        idle();
        commit(0, 7, 9, 32'h11);
        step();
        idle();
        push("stale_commit", 1'b0, 7, 32'h11, 1'b1, 1'b1, 12);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
        commit(0, 7, 12, 32'h22);
        step();
        idle();
        push("owner_commit", 1'b0, 7, 32'h22, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    task automatic test_simultaneous();
        disp(3, 4);
        step();
        idle();
        commit(0, 3, 4, 32'hA);
        commit(1, 3, 4, 32'hB);
        disp(3, 6);
        step();
        idle();
        push("simul_rename_wins", 1'b0, 3, 32'hB, 1'b1, 1'b1, 6);
        // Busy clear when only one of two ports carries the owning tag
        disp(10, 5);
        step();
        idle();
        commit(0, 10, 7, 32'h1);
        commit(1, 10, 5, 32'h2);
        step();
        idle();
        disp(11, 5);
        step();
        idle();
        commit(0, 11, 5, 32'h3);
        commit(1, 11, 8, 32'h4);
        step();
        idle();
        push("port1_tag_clears", 1'b0, 10, 32'h2, 1'b0, 1'b0, 0);
        push("port0_tag_clears", 1'b1, 11, 32'h4, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    task automatic test_x0_rollback();
        disp(0, 7);
        commit(0, 0, 0, 32'hFFFF_FFFF);
        step();
        idle();
        push("x0_p2", 1'b1, 0, '0, 1'b0, 1'b1, 0);
        push("x0_p1", 1'b0, 0, '0, 1'b0, 1'b1, 0);
        disp(1, 1);
        step();
        disp(2, 2);
        step();
        idle();
        rf.rollback = 1'b1;
        disp(4, 3);
        commit(0, 9, 1, 32'h55);
        step();
        idle();
        push("rollback_x1", 1'b0, 1, '0, 1'b0, 1'b0, 0);
        push("rollback_x2", 1'b1, 2, '0, 1'b0, 1'b0, 0);
        push("rollback_disp", 1'b0, 4, '0, 1'b0, 1'b0, 0);
        push("rollback_commit", 1'b1, 9, 32'h55, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    task automatic test_rdy();
        commit(0, 12, 0, 32'h99);
        step();
        idle();
        disp(14, 4);
        step();
        idle();
        rdy = 1'b0;
        commit(0, 12, 0, 32'hBAD);
        commit(1, 14, 4, 32'hBAD);
        disp(13, 2);
        step();
        rf.rollback = 1'b1;
        step();
        idle();
        push("rdy_low_value", 1'b0, 12, 32'h99, 1'b0, 1'b0, 0);
        push("rdy_low_rename", 1'b1, 13, '0, 1'b0, 1'b0, 0);
        push("rdy_low_hold", 1'b0, 14, '0, 1'b1, 1'b1, 4);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    task automatic test_bypass();
        disp(7, 9);
        step();
        idle();
        commit(0, 7, 9, 32'h77);
`ifdef RENAME_REGFILE_BYPASS_EN
        push("same_cycle_read", 1'b0, 7, 32'h77, 1'b0, 1'b1, 0);
`else
        push("same_cycle_read", 1'b0, 7, 32'h22, 1'b1, 1'b1, 9);
`endif
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
        step();
        idle();
        push("after_commit", 1'b0, 7, 32'h77, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port) rf.rs2 = e.rs; else rf.rs1 = e.rs;
            #1;
            gv = e.port ? rf.v2 : rf.v1; gq = e.port ? rf.q2 : rf.q1; gb = e.port ? rf.busy2 : rf.busy1;
            checks++;
            if (gv !== e.v || gb !== e.busy || (e.chk_q && gq !== e.q)) begin
                errors++;
                $display("FAIL %s x%0d: got v=%h busy=%b q=%0d, expected v=%h busy=%b q=%0d",
                         e.name, e.rs, gv, gb, gq, e.v, e.busy, e.q);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        rf.rs1 = '0;
        rf.rs2 = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        test_reset();
        test_reset_async();
        test_rename_commit();
        test_stale_commit();
        test_simultaneous();
        test_x0_rollback();
        test_rdy();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
